muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Multi-cycle sequencer for the MIPS multiply/divide datapath. It owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Executes MTHI and MTLO in a single cycle.
- Drives a busy/ready handshake so the pipeline can stall while an operation is in flight.
- Sits beside the ALU in EX; MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- CNT_W, 6: iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; accepted only when ready=1
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
- src_a  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data)
- src_b  in  WIDTH  rt operand (multiplier/divisor)
- ready  out  1  high in IDLE; equals ~busy
- busy  out  1  high while a mul/div is in flight (pipeline stall)
- done  out  1  one-cycle pulse in the cycle HI/LO are written by mul/div
- div_zero  out  1  sticky flag: last DIV/DIVU had src_b==0; cleared by the next accepted mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset:
  - state=IDLE; hi=lo=0; busy=done=div_zero=0; ready=1.
  - Reset takes priority over everything, including mid-operation: the in-flight op is abandoned, no done pulse, HI/LO cleared.
- States: IDLE, PREP, CALC, FIX.
- IDLE:
  - start & op=MTHI: hi<=src_a at the next edge; stay in IDLE.
  - start & op=MTLO: lo<=src_a at the next edge; stay in IDLE.
  - start & reserved op: ignored, no state change.
  - start & mul/div op: latch op, src_a, src_b; clear div_zero; go to PREP.
- PREP (1 cycle):
  - Signed ops take magnitudes |a| and |b|.
  - Record sign flags: sq = a[31]^b[31] (product/quotient sign); sr = a[31] (remainder sign).
  - Unsigned ops use the raw operands with sq=sr=0.
  - Clear the 2*WIDTH accumulator; cnt<=0; go to CALC.
- CALC (exactly WIDTH cycles):
  - Multiply: shift-add on the 64-bit {acc_hi, acc_lo}.
  - Divide: restoring shift-subtract. Partial remainder is in acc_hi, quotient bits shift into acc_lo.
  - cnt increments each cycle; at cnt==WIDTH-1 go to FIX.
- FIX (1 cycle):
  - Multiply: negate the 64-bit product if sq.
  - Divide: negate the quotient if sq; negate the remainder if sr.
  - Result mapping: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
  - done=1 this cycle; HI/LO written at the closing edge; return to IDLE.
- Timing:
  - Start accepted at edge T. busy is high for cycles T+1..T+34; done is high in T+34.
  - New hi/lo are visible from T+35, when ready=1 again.
  - Total 34-cycle occupancy for every mul/div.
- start while busy:
  - Ignored, not queued. The requester must hold start until ready.
  - An MTHI/MTLO arriving while busy is also ignored.
- Divide by zero (src_b==0):
  - The algorithm runs unmodified: LO=32'hFFFFFFFF, HI=dividend magnitude before sign fix-up.
  - Signed: LO=FFFFFFFF negated if sq; HI = src_a (remainder sign = sr).
  - div_zero=1 from T+35.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
- hi and lo are held stable throughout busy; only FIX or MTHI/MTLO modify them.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encodings OP_MULT..OP_MTLO;
  - the state encoding ST_IDLE/ST_PREP/ST_CALC/ST_FIX;
  - the WIDTH default.
- One natural sub-module: muldiv_iter_core. It is the accumulator plus the per-cycle shift-add/shift-sub step, with inputs step, is_div and the operand magnitudes.
- The FSM, sign handling, HI/LO registers and handshake remain in muldiv_hilo_ctrl.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at T+35; busy high for exactly 34 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100, div_zero=1. The next MULTU 2×3 clears div_zero; hi=0, lo=6.
- MTHI 0x12345678 in IDLE → hi=0x12345678 next cycle with no busy. Start DIV 10/3, pulse MTLO 0xDEAD at T+5 → ignored; final lo=3, hi=1.
- Start MULT 6×7, assert reset at T+10 for one cycle → busy=0, hi=lo=0, no done pulse. A fresh MULT 6×7 afterward → lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
//   MULDIV_WIDTH      default operand and HI/LO width
//   OP_*              3-bit operation codes presented on 'op' (11x is reserved)
//   ST_*              sequencer state encoding
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PREP = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative accumulator for unsigned multiply (MSB-first shift-add) and
// restoring divide (shift-subtract). One operand bit is consumed per step.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          zero the accumulator and load the bit-serial operand
//   step           perform one iteration
//   isDiv          1 = divide, 0 = multiply
//   magA, magB     unsigned operand magnitudes (held stable while stepping)
//   accHi, accLo   accumulator halves: product, or remainder/quotient
import muldiv_pkg::*;

module muldiv_iter_core #(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] magA,
    input  logic [WIDTH-1:0] magB,
    output logic [WIDTH-1:0] accHi,
    output logic [WIDTH-1:0] accLo
);

    // Multiply consumes the multiplier MSB-first; divide shifts the dividend
    // MSB-first into the partial remainder. Both use the same shift register.
    logic [WIDTH-1:0]   shReg;
    logic [WIDTH:0]     trial;
    logic               qBit;
    logic [WIDTH-1:0]   remNext;
    logic [2*WIDTH-1:0] mulNext;

    always_comb begin
        // Partial remainder stays below magB, so WIDTH+1 bits hold 2*rem+bit;
        // the top bit of the difference acts as the borrow.
        trial   = {accHi, shReg[WIDTH-1]} - {1'b0, magB};
        qBit    = ~trial[WIDTH];
        remNext = qBit ? trial[WIDTH-1:0] : {accHi[WIDTH-2:0], shReg[WIDTH-1]};
        mulNext = {accHi[WIDTH-2:0], accLo, 1'b0}
                + (shReg[WIDTH-1] ? {{WIDTH{1'b0}}, magA} : {2*WIDTH{1'b0}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            accHi <= '0;
            accLo <= '0;
            shReg <= '0;
        end else if (clear) begin
            accHi <= '0;
            accLo <= '0;
            shReg <= isDiv ? magA : magB;
        end else if (step) begin
            if (isDiv) begin
                accHi <= remNext;
                accLo <= {accLo[WIDTH-2:0], qBit};
            end else begin
                {accHi, accLo} <= mulNext;
            end
            shReg <= {shReg[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// MIPS multiply/divide sequencer owning the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run iteratively (34-cycle occupancy); MTHI/MTLO write
// in one cycle from IDLE.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start, op        request strobe and operation code (accepted when ready)
//   src_a, src_b     rs / rt operands
//   ready, busy      handshake: ready = ~busy
//   done             one-cycle pulse while HI/LO are being written by mul/div
//   div_zero         sticky: last divide had a zero divisor
//   hi, lo           architectural HI/LO
//
// state | meaning
// IDLE  | waiting; MTHI/MTLO serviced here
// PREP  | take magnitudes, record sign flags, clear accumulator
// CALC  | WIDTH iterations of shift-add / shift-subtract
// FIX   | apply signs, write HI/LO, pulse done
import muldiv_pkg::*;

module muldiv_hilo_ctrl #(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic             isSignedReg;
    logic             isDivReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             sq;
    logic             sr;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    assign busy  = (state != ST_IDLE);
    assign ready = ~busy;
    assign done  = (state == ST_FIX);

    always_comb begin
        magA = (isSignedReg && aReg[WIDTH-1]) ? -aReg : aReg;
        magB = (isSignedReg && bReg[WIDTH-1]) ? -bReg : bReg;
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) uCore (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_PREP),
        .step  (state == ST_CALC),
        .isDiv (isDivReg),
        .magA  (magA),
        .magB  (magB),
        .accHi (accHi),
        .accLo (accLo)
    );

    always_comb begin
        prodFix = sq ? -{accHi, accLo} : {accHi, accLo};
        if (isDivReg) begin
            fixLo = sq ? -accLo : accLo;
            fixHi = sr ? -accHi : accHi;
        end else begin
            fixHi = prodFix[2*WIDTH-1:WIDTH];
            fixLo = prodFix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            isSignedReg <= 1'b0;
            isDivReg    <= 1'b0;
            aReg        <= '0;
            bReg        <= '0;
            sq          <= 1'b0;
            sr          <= 1'b0;
            cnt         <= '0;
            div_zero    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                isSignedReg <= ~op[0];
                                isDivReg    <= op[1];
                                aReg        <= src_a;
                                bReg        <= src_b;
                                div_zero    <= 1'b0;
                                state       <= ST_PREP;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PREP: begin
                    sq    <= isSignedReg & (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
                    sr    <= isSignedReg & aReg[WIDTH-1];
                    cnt   <= '0;
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi <= fixHi;
                    lo <= fixLo;
                    if (isDivReg) begin
                        div_zero <= (bReg == '0);
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl: expected HI/LO/div_zero come from an
// arithmetic reference model, are queued at issue, and are checked when done
// pulses.
import muldiv_pkg::*;

module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        ready;
    logic        busy;
    logic        done;
    logic        divZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int passCnt = 0;
    int totalCnt = 0;
    logic [64:0] sbQ[$];
    logic [64:0] monExp;

    muldiv_hilo_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (srcA),
        .src_b    (srcB),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .div_zero (divZero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: {div_zero, hi, lo} from plain SV arithmetic.
    function automatic logic [64:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp, sqt, srm;
        logic [63:0] up;
        logic [31:0] rh, rl;
        logic dz;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        dz = 1'b0; rh = '0; rl = '0;
        case (o)
            OP_MULT: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
            OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
            OP_DIV: begin
                if (b == 0) begin
                    dz = 1'b1; rh = a; rl = a[31] ? 32'h1 : 32'hFFFFFFFF;
                end else begin
                    sqt = sa / sb; srm = sa % sb; rl = sqt[31:0]; rh = srm[31:0];
                end
            end
            OP_DIVU: begin
                if (b == 0) begin dz = 1'b1; rh = a; rl = 32'hFFFFFFFF; end
                else begin rl = a / b; rh = a % b; end
            end
            default: ;
        endcase
        return {dz, rh, rl};
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            @(posedge clk);
            #1;
            checkVal("sb_nonempty", 64'(sbQ.size() != 0), 1);
            if (sbQ.size() != 0) begin
                monExp = sbQ.pop_front();
                checkVal("hi", hi, monExp[63:32]);
                checkVal("lo", lo, monExp[31:0]);
                checkVal("div_zero", divZero, monExp[64]);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int doneAt, busyCnt, holdErr;
        logic [31:0] hi0, lo0;
        sbQ.push_back(refModel(o, a, b));
        hi0 = hi; lo0 = lo;
        issue(o, a, b);
        doneAt = 0; busyCnt = 0; holdErr = 0;
        for (int k = 1; k <= 40 && doneAt == 0; k++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (hi !== hi0 || lo !== lo0) holdErr++;
            if (done) doneAt = k;
        end
        checkVal("done_cycle", doneAt, 34);
        checkVal("busy_cycles", busyCnt, 34);
        checkVal("hold_hilo", holdErr, 0);
        @(posedge clk);
        #1;
        checkVal("ready_after", ready, 1);
    endtask

    task automatic waitIdle();
        int k;
        k = 0;
        while (!ready && k < 60) begin @(negedge clk); k++; end
        checkVal("idle_reached", ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hiKeep, loKeep;
        int doneCnt;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        checkVal("rst_ready", ready, 1);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_div_zero", divZero, 0);
        checkVal("rst_hi", hi, 0);
        checkVal("rst_lo", lo, 0);

        runOp(OP_MULT, 32'hFFFFFFFD, 32'd5);
        runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp(OP_DIV, 32'hFFFFFFF9, 32'd2);
        runOp(OP_DIVU, 32'd100, 32'd7);
        runOp(OP_DIVU, 32'd100, 32'd0);
        runOp(OP_MULTU, 32'd2, 32'd3);
        runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        runOp(OP_DIV, 32'hFFFFFFF9, 32'd0);

        // MTHI in IDLE: visible next cycle, never busy.
        issue(OP_MTHI, 32'h12345678, 32'd0);
        checkVal("mthi_hi", hi, 32'h12345678);
        checkVal("mthi_busy", busy, 0);

        // Reserved op is ignored.
        hiKeep = hi; loKeep = lo;
        issue(3'b110, 32'hCAFEF00D, 32'd1);
        checkVal("rsvd_busy", busy, 0);
        checkVal("rsvd_hi", hi, hiKeep);
        checkVal("rsvd_lo", lo, loKeep);

        // MTLO while a divide is in flight is dropped.
        sbQ.push_back(refModel(OP_DIV, 32'd10, 32'd3));
        loKeep = lo;
        issue(OP_DIV, 32'd10, 32'd3);
        repeat (5) @(negedge clk);
        start = 1'b1; op = OP_MTLO; srcA = 32'h0000DEAD;
        @(posedge clk);
        #1 start = 1'b0;
        checkVal("mtlo_busy_lo", lo, loKeep);
        checkVal("mtlo_busy_still", busy, 1);
        waitIdle();

        // Reset mid-operation abandons the op with no done pulse.
        issue(OP_MULT, 32'd6, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checkVal("midrst_busy", busy, 0);
        checkVal("midrst_ready", ready, 1);
        checkVal("midrst_hi", hi, 0);
        checkVal("midrst_lo", lo, 0);
        doneCnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkVal("midrst_no_done", doneCnt, 0);
        runOp(OP_MULT, 32'd6, 32'd7);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            runOp(rop, ra, rb);
        end

        checkVal("sb_drained", sbQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
